mux_scan_serializer: RTL and testbench
======================================

// Module: mux_scan_serializer
// PURPOSE
//  Upstream driver for the 7:1 bit mux: latches a 7-bit word, presents it on data_bus and
//  steps select_bus 0..6, turning the mux output into a timed serial bit stream, LSB first.
//  Load/ready handshake upstream. serial_out/serial_valid/done downstream.
// PARAMETERS
//  DIV         4   clock cycles each bit is held. Legal range 1..255.
//  IDLE_LEVEL  1   serial_out level whenever no bit is being shifted.
// PORTS
//  clk           in   1  single clock, rising edge
//  resetn        in   1  asynchronous, active-low reset
//  load          in   1  start request; accepted only when ready=1
//  word          in   7  word to serialize; sampled when load is accepted
//  ready         out  1  1 = IDLE, load will be accepted
//  data_bus      out  7  latched word, drives the mux data input
//  select_bus    out  3  bit index, drives the mux select
//  mux_out       in   1  mux output, combinational from data_bus/select_bus
//  serial_out    out  1  serial bit stream
//  serial_valid  out  1  1 while serial_out carries a frame bit
//  done          out  1  one-cycle pulse after the last bit period
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state=IDLE, data_bus=0, select_bus=3'b111,
//   div_cnt=0, done=0, ready=1, serial_valid=0, serial_out=IDLE_LEVEL.
//   select 3'b111 parks the mux on its default output (0).
//  Registers: state, data_bus, select_bus, 8-bit div_cnt, done.
//  States: IDLE -> SHIFT -> [PARITY] -> DONE -> IDLE.
//  IDLE: ready=1. On load=1 at an edge: data_bus<=word, select_bus<=0, div_cnt<=0, go SHIFT.
//  SHIFT: serial_out=mux_out (combinational), serial_valid=1, ready=0.
//   Each clock: div_cnt<=div_cnt+1. When div_cnt==DIV-1: div_cnt<=0, and:
//   - select_bus<6: select_bus<=select_bus+1;
//   - select_bus==6: leave SHIFT.
//   SHIFT lasts exactly 7*DIV cycles.
//  DONE: single cycle. done=1, serial_valid=0, serial_out=IDLE_LEVEL, select_bus<=3'b111.
//   Next state is IDLE.
//  Latency: load accepted at edge 0 -> bit0 on cycles 1..DIV -> done on cycle 7*DIV+1
//   -> ready=1 on cycle 7*DIV+2.
//  load when ready=0 is ignored; it is not queued. load held high restarts on the first
//   IDLE cycle. word changes after acceptance have no effect; data_bus is stable all frame.
//  DIV=1: one bit per cycle. No wrap: select_bus never exceeds 6 in SHIFT.
//  serial_out/serial_valid/ready are decoded from state, so they are glitch-free at
//   registered edges. mux_out is only used in SHIFT.
// CONFIGURATION
//  MUX_SCAN_PARITY_EN defined:
//   - After bit 6, go to PARITY for DIV cycles.
//   - In PARITY: serial_out=^data_bus (even parity), serial_valid=1, select_bus=3'b111.
//   - Then go to DONE. Frame length is 8*DIV; done on cycle 8*DIV+1.
//  MUX_SCAN_PARITY_EN undefined:
//   - No PARITY state; SHIFT goes straight to DONE as described above.
// TESTING (behavioural 7:1 mux model in the bench; DIV=4, IDLE_LEVEL=1 unless stated)
//  1. Reset asserted -> ready=1, select_bus=7, data_bus=0, serial_out=1, valid=0, done=0.
//  2. load, word=7'b1010011 at edge 0 -> serial_out 1,1,0,0,1,0,1, each held 4 cycles
//     (cycles 1..28); done=1 on cycle 29; ready=1 on cycle 30.
//  3. load pulsed on cycle 10 with word=7'h7F -> ignored: stream unchanged, data_bus stays 7'h53.
//  4. resetn low on cycle 13 (mid-frame) -> same cycle: ready=1, select_bus=7, valid=0, no done.
//     New load after release -> full normal frame.
//  5. DIV=1, load held high continuously -> frames of 7 bits, then 1 DONE cycle, then 1 IDLE
//     cycle; a new frame starts every 9 cycles.
//  6. MUX_SCAN_PARITY_EN, word=7'b1010011 -> 8th bit (cycles 29..32) is 0; done on cycle 33.
//     With word=7'b0000001 the 8th bit is 1.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: steps a 7:1 mux through a latched word to emit a timed serial stream, LSB first.
// Define MUX_SCAN_PARITY_EN to append an even-parity bit after bit 6.
module mux_scan_serializer #(
    parameter int DIV        = 4,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [6:0] word,
    output logic       ready,
    output logic [6:0] data_bus,
    output logic [2:0] select_bus,
    input  logic       mux_out,
    output logic       serial_out,
    output logic       serial_valid,
    output logic       done
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef MUX_SCAN_PARITY_EN
        PARITY = 2'd3,
`endif
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(DIV - 1);

    state_t     state, next_state;
    logic [7:0] div_cnt;
    logic       bit_end, last_bit;

    assign bit_end  = div_cnt == LAST;
    assign last_bit = select_bus == 3'd6;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = load ? SHIFT : IDLE;
`ifdef MUX_SCAN_PARITY_EN
            SHIFT:   next_state = (bit_end && last_bit) ? PARITY : SHIFT;
            PARITY:  next_state = bit_end ? DONE : PARITY;
`else
            SHIFT:   next_state = (bit_end && last_bit) ? DONE : SHIFT;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready        = state == IDLE;
`ifdef MUX_SCAN_PARITY_EN
        serial_valid = state == SHIFT || state == PARITY;
        serial_out   = state == SHIFT ? mux_out : (state == PARITY ? ^data_bus : IDLE_LEVEL);
`else
        serial_valid = state == SHIFT;
        serial_out   = state == SHIFT ? mux_out : IDLE_LEVEL;
`endif
    end

    // select_bus holds at 6 after the last bit (no wrap) until DONE parks it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_bus   <= 7'd0;
            select_bus <= 3'b111;
            div_cnt    <= 8'd0;
            done       <= 1'b0;
        end else begin
            done <= next_state == DONE;
            case (state)
                IDLE: if (load) begin
                    data_bus   <= word;
                    select_bus <= 3'd0;
                    div_cnt    <= 8'd0;
                end
                SHIFT: begin
                    div_cnt <= bit_end ? 8'd0 : div_cnt + 8'd1;
                    if (bit_end && !last_bit) select_bus <= select_bus + 3'd1;
`ifdef MUX_SCAN_PARITY_EN
                    if (bit_end && last_bit) select_bus <= 3'b111;
`endif
                end
`ifdef MUX_SCAN_PARITY_EN
                PARITY: div_cnt <= bit_end ? 8'd0 : div_cnt + 8'd1;
`endif
                DONE: begin
                    select_bus <= 3'b111;
                    div_cnt    <= 8'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: directed bench with a queue scoreboard of expected serial bits.
module tb_mux_scan_serializer;
`ifdef MUX_SCAN_PARITY_EN
    localparam int FB = 8;
`else
    localparam int FB = 7;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0, load = 1'b0;
    logic [6:0] word = 7'd0;
    logic       ready, mux_out, serial_out, serial_valid, done;
    logic [6:0] data_bus;
    logic [2:0] select_bus;

    logic       resetn1 = 1'b0, load1 = 1'b0;
    logic [6:0] word1 = 7'd0;
    logic       ready1, mux_out1, serial_out1, serial_valid1, done1;
    logic [6:0] data_bus1;
    logic [2:0] select_bus1;

    int   checks = 0, failures = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    assign mux_out  = select_bus <= 3'd6 ? data_bus[select_bus] : 1'b0;
    assign mux_out1 = select_bus1 <= 3'd6 ? data_bus1[select_bus1] : 1'b0;

    mux_scan_serializer #(.DIV(4), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .resetn(resetn), .load(load), .word(word), .ready(ready),
        .data_bus(data_bus), .select_bus(select_bus), .mux_out(mux_out),
        .serial_out(serial_out), .serial_valid(serial_valid), .done(done));

    mux_scan_serializer #(.DIV(1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .resetn(resetn1), .load(load1), .word(word1), .ready(ready1),
        .data_bus(data_bus1), .select_bus(select_bus1), .mux_out(mux_out1),
        .serial_out(serial_out1), .serial_valid(serial_valid1), .done(done1));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [6:0] w, input int div);
        for (int b = 0; b < 7; b++)
            for (int d = 0; d < div; d++) exp_q.push_back(w[b]);
`ifdef MUX_SCAN_PARITY_EN
        for (int d = 0; d < div; d++) exp_q.push_back(^w);
`endif
    endtask

    task automatic pop_check(input string tag, input logic obs);
        if (exp_q.size() == 0) check({tag, "_underflow"}, 8'd1, 8'd0);
        else check(tag, obs, exp_q.pop_front());
    endtask

    task automatic run_frame(input logic [6:0] w, input bit inject);
        exp_q.delete();
        word = w;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        push_frame(w, 4);
        for (int c = 1; c <= FB * 4; c++) begin
            check("valid", serial_valid, 8'd1);
            check("ready_busy", ready, 8'd0);
            check("data_bus", data_bus, w);
            pop_check("serial", serial_out);
            if (inject && c == 10) begin
                word = 7'h7F;
                load = 1'b1;
            end else if (inject && c == 11) begin
                load = 1'b0;
                word = w;
            end
            @(posedge clk); #1;
        end
        check("done_pulse", done, 8'd1);
        check("done_valid", serial_valid, 8'd0);
        check("done_idle_level", serial_out, 8'd1);
        check("done_ready", ready, 8'd0);
        @(posedge clk); #1;
        check("ready_after", ready, 8'd1);
        check("done_cleared", done, 8'd0);
        check("select_parked", select_bus, 8'd7);
        check("queue_empty", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        #1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 8'd1);
        check("rst_select", select_bus, 8'd7);
        check("rst_data", data_bus, 8'd0);
        check("rst_serial", serial_out, 8'd1);
        check("rst_valid", serial_valid, 8'd0);
        check("rst_done", done, 8'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_frame(7'b1010011, 1'b1);
        run_frame(7'b0000001, 1'b0);

        word = 7'h2C;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_valid_before", serial_valid, 8'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", ready, 8'd1);
        check("mid_rst_select", select_bus, 8'd7);
        check("mid_rst_valid", serial_valid, 8'd0);
        check("mid_rst_done", done, 8'd0);
        check("mid_rst_serial", serial_out, 8'd1);
        #1 resetn = 1'b1;
        run_frame(7'b0110110, 1'b0);

        exp_q.delete();
        #2 resetn1 = 1'b1;
        word1 = 7'b0110101;
        load1 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 3 * (FB + 2); c++) begin
            int p;
            p = (c - 1) % (FB + 2);
            if (p == 0) push_frame(word1, 1);
            if (p < FB) begin
                check("div1_valid", serial_valid1, 8'd1);
                pop_check("div1_serial", serial_out1);
            end else if (p == FB) begin
                check("div1_done", done1, 8'd1);
                check("div1_done_valid", serial_valid1, 8'd0);
            end else begin
                check("div1_idle_ready", ready1, 8'd1);
                check("div1_idle_done", done1, 8'd0);
            end
            @(posedge clk); #1;
        end
        load1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
